// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory bus and IF/ID outputs.
// Perf counter signals exist only when FETCH_PERF_EN is defined.
interface fetch_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  stall_f;
    logic                  stall_d;
    logic                  flush_d;
    logic                  pc_src_e;
    logic [DATA_WIDTH-1:0] pc_target_e;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rd;
    logic [DATA_WIDTH-1:0] instr_d;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pcplus4_d;
    logic                  valid_d;
    logic                  misalign_f;
`ifdef FETCH_PERF_EN
    logic [31:0]           fetch_count;
    logic [31:0]           stall_count;
`endif

    modport master (
`ifdef FETCH_PERF_EN
        output fetch_count,
        output stall_count,
`endif
        input  stall_f,
        input  stall_d,
        input  flush_d,
        input  pc_src_e,
        input  pc_target_e,
        input  imem_rd,
        output imem_addr,
        output instr_d,
        output pc_d,
        output pcplus4_d,
        output valid_d,
        output misalign_f
    );

    modport slave (
`ifdef FETCH_PERF_EN
        input  fetch_count,
        input  stall_count,
`endif
        output stall_f,
        output stall_d,
        output flush_d,
        output pc_src_e,
        output pc_target_e,
        output imem_rd,
        input  imem_addr,
        input  instr_d,
        input  pc_d,
        input  pcplus4_d,
        input  valid_d,
        input  misalign_f
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem addressing and the IF/ID pipeline register.
// Optional FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h00000000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    logic [DATA_WIDTH-1:0] pc_f;
    logic [DATA_WIDTH-1:0] pcplus4_f;
    logic [DATA_WIDTH-1:0] instr_d;
    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pcplus4_d;
    logic                  valid_d;
    logic                  misalign_f;
    logic                  bubble_d;
    logic                  load_d;

    assign pcplus4_f = pc_f + DATA_WIDTH'(4);
    // A redirect squashes the wrong-path word currently being fetched.
    assign bubble_d  = bus.flush_d | bus.pc_src_e;
    assign load_d    = ~bubble_d & ~bus.stall_d;

    // ---- IF stage: PC register and redirect ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_f       <= RESET_PC;
            misalign_f <= 1'b0;
        end else begin
            if (bus.pc_src_e)
                pc_f <= {bus.pc_target_e[DATA_WIDTH-1:2], 2'b00};
            else if (!bus.stall_f)
                pc_f <= pcplus4_f;
            misalign_f <= bus.pc_src_e & (bus.pc_target_e[1:0] != 2'b00);
        end
    end

    // ---- IF/ID boundary ----
    always_ff @(posedge clk) begin
        if (!rst || bubble_d) begin
            instr_d   <= NOP_INSTR;
            pc_d      <= '0;
            pcplus4_d <= '0;
            valid_d   <= 1'b0;
        end else if (load_d) begin
            instr_d   <= bus.imem_rd;
            pc_d      <= pc_f;
            pcplus4_d <= pcplus4_f;
            valid_d   <= 1'b1;
        end
    end

    assign bus.imem_addr  = pc_f;
    assign bus.instr_d    = instr_d;
    assign bus.pc_d       = pc_d;
    assign bus.pcplus4_d  = pcplus4_d;
    assign bus.valid_d    = valid_d;
    assign bus.misalign_f = misalign_f;

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [31:0] fetch_count;
    logic [31:0] stall_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (load_d)
                fetch_count <= sat_inc(fetch_count);
            if (bus.stall_f && !bus.pc_src_e)
                stall_count <= sat_inc(stall_count);
        end
    end

    assign bus.fetch_count = fetch_count;
    assign bus.stall_count = stall_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage, plus reset-during-stall sequence.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    fetch_stage_if #(.DATA_WIDTH(32)) bus ();

    fetch_stage #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00500093;
            32'h4:   return 32'h00100113;
            default: return 32'hA5000000 ^ a;
        endcase
    endfunction

    assign bus.imem_rd = imem_word(bus.imem_addr);

    typedef struct {
        logic        sf, sd, fl, src;
        logic [31:0] tgt;
        logic [31:0] pc, instr, pcd, p4;
        logic        vld, mis;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic sf, sd, fl, src, input logic [31:0] tgt,
                                input logic [31:0] pc, instr, pcd, p4,
                                input logic vld, mis);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fl = fl; v.src = src; v.tgt = tgt;
        v.pc = pc; v.instr = instr; v.pcd = pcd; v.p4 = p4; v.vld = vld; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " imem_addr"}, bus.imem_addr, v.pc);
        chk({tag, " instr_d"}, bus.instr_d, v.instr);
        chk({tag, " pc_d"}, bus.pc_d, v.pcd);
        chk({tag, " pcplus4_d"}, bus.pcplus4_d, v.p4);
        chk({tag, " valid_d"}, {31'd0, bus.valid_d}, {31'd0, v.vld});
        chk({tag, " misalign_f"}, {31'd0, bus.misalign_f}, {31'd0, v.mis});
    endtask

    task automatic drive(input vec_t v);
        bus.stall_f     = v.sf;
        bus.stall_d     = v.sd;
        bus.flush_d     = v.fl;
        bus.pc_src_e    = v.src;
        bus.pc_target_e = v.tgt;
    endtask

    initial begin
        vec_t z;
        //                sf    sd    fl    src   tgt            pc             instr          pc_d           pc+4           vld   mis
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h00500093, 32'h0,        32'h4,        1'b1, 1'b0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0);
        vecs[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'hA5000008, 32'h8,        32'hC,        1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h40,       32'h40,       32'h00000013, 32'h0,        32'h0,        1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'hA5000040, 32'h40,       32'h44,       1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h42,       32'h40,       32'h00000013, 32'h0,        32'h0,        1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'hA5000040, 32'h40,       32'h44,       1'b1, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h48,       32'h00000013, 32'h0,        32'h0,        1'b0, 1'b0);
        vecs[11] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h48,       32'hA5000048, 32'h48,       32'h4C,       1'b1, 1'b0);
        vecs[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h48,       32'hA5000048, 32'h48,       32'h4C,       1'b1, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h4C,       32'hA5000048, 32'h48,       32'h4C,       1'b1, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000013, 32'h0,        32'h0,        1'b0, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h5AFFFFFC, 32'hFFFFFFFC, 32'h0,        1'b1, 1'b0);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h00500093, 32'h0,        32'h4,        1'b1, 1'b0);
        vecs[17] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h4,        32'h00500093, 32'h0,        32'h4,        1'b1, 1'b0);

        // Reset state
        z = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h00000013, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(z);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", z);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
            @(negedge clk);
        end

`ifdef FETCH_PERF_EN
        chk("fetch_count before reset", bus.fetch_count, 32'd9);
        chk("stall_count before reset", bus.stall_count, 32'd6);
`endif

        // Reset during a stall with a redirect pending: reset must win.
        bus.stall_f     = 1'b1;
        bus.stall_d     = 1'b1;
        bus.pc_src_e    = 1'b1;
        bus.pc_target_e = 32'h82;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_in_stall", z);
`ifdef FETCH_PERF_EN
        chk("fetch_count after reset", bus.fetch_count, 32'd0);
        chk("stall_count after reset", bus.stall_count, 32'd0);
`endif

        // Release reset: first fetch after reset lands on the next edge.
        @(negedge clk);
        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset", vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
